// File: rtl/clk_div_monitor_pkg.sv
// Shared state encoding and default divisor/lock constants for the PHY clock monitor.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } mon_state_e;

  localparam int DF_1_DEFAULT     = 32;
  localparam int DF_2_DEFAULT     = 16;
  localparam int DF_4_DEFAULT     = 8;
  localparam int LOCK_CNT_DEFAULT = 4;
  localparam int CW_DEFAULT       = 8;

endpackage

// File: rtl/clk_div_monitor_checker.sv
// div_period_checker: samples one divided clock on clk_32f, tracks period lock and a sticky error.
// DUTY_CHECK_EN defined: the high time is also verified at every falling edge.
module div_period_checker
  import clk_div_monitor_pkg::*;
#(
  parameter int EXP      = DF_4_DEFAULT,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic clk_32f,
  input  logic reset_L,
  input  logic clk_in,
  input  logic err_clr,
  output logic locked,
  output logic err
);

  localparam int            GW        = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CW-1:0] CNT_GOOD  = CW'(EXP - 1);
  localparam logic [CW-1:0] CNT_TMO   = CW'(2 * EXP - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  logic          r_s0;
  logic          r_s1;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_good;
  logic [GW-1:0] w_good_nxt;
  mon_state_e    r_state;
  mon_state_e    w_state_nxt;
  logic          r_locked;
  logic          r_err;
  logic          w_rise;
  logic          w_good_per;
  logic          w_bad_per;
  logic          w_tmo;
  logic          w_bad_duty;
  logic          w_err_set;

  assign w_rise     = r_s0 & ~r_s1;
  assign w_good_per = w_rise & (r_cnt == CNT_GOOD);
  assign w_bad_per  = w_rise & (r_cnt != CNT_GOOD);
  assign w_tmo      = ~w_rise & (r_cnt == CNT_TMO);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s0 <= clk_in;
      r_s1 <= r_s0;
      if (w_rise) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef DUTY_CHECK_EN
  localparam logic [CW-1:0] HI_GOOD = CW'(EXP / 2 - 1);
  logic [CW-1:0] r_hi;
  logic          w_fall;

  assign w_fall = ~r_s0 & r_s1;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_hi <= '0;
    end else if (w_rise) begin
      r_hi <= '0;
    end else if (r_hi != '1) begin
      r_hi <= r_hi + 1'b1;
    end
  end

  assign w_bad_duty = w_fall & (r_hi != HI_GOOD);
`else
  assign w_bad_duty = 1'b0;
`endif

  // Timeout and rise are exclusive; a fall never coincides with a rise either.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_ACQ;
          w_good_nxt  = '0;
        end
      end
      ST_ACQ: begin
        if (w_tmo) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bad_per || w_bad_duty) begin
          w_good_nxt = '0;
        end else if (w_good_per) begin
          if (r_good == GOOD_LAST) begin
            w_state_nxt = ST_LOCK;
          end else begin
            w_good_nxt = r_good + 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (w_tmo) begin
          w_state_nxt = ST_IDLE;
          w_err_set   = 1'b1;
        end else if (w_bad_per || w_bad_duty) begin
          w_state_nxt = ST_ACQ;
          w_good_nxt  = '0;
          w_err_set   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= ST_IDLE;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_locked <= (r_state == ST_LOCK);
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign locked = r_locked;
  assign err    = r_err;

endmodule

// File: rtl/clk_div_monitor.sv
// Checks clk_f/clk_2f/clk_4f against clk_32f; per-clock lock and sticky error, registered all_locked.
// DUTY_CHECK_EN defined: each checker also verifies the high time of its clock.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int DF_1     = DF_1_DEFAULT,
  parameter int DF_2     = DF_2_DEFAULT,
  parameter int DF_4     = DF_4_DEFAULT,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic clk_32f,
  input  logic reset_L,
  input  logic clk_f,
  input  logic clk_2f,
  input  logic clk_4f,
  input  logic err_clr,
  output logic locked_f,
  output logic locked_2f,
  output logic locked_4f,
  output logic all_locked,
  output logic err_f,
  output logic err_2f,
  output logic err_4f
);

  logic r_all_locked;

  div_period_checker #(.EXP(DF_1), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_chk_f (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .clk_in  (clk_f),
    .err_clr (err_clr),
    .locked  (locked_f),
    .err     (err_f)
  );

  div_period_checker #(.EXP(DF_2), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_chk_2f (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .clk_in  (clk_2f),
    .err_clr (err_clr),
    .locked  (locked_2f),
    .err     (err_2f)
  );

  div_period_checker #(.EXP(DF_4), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_chk_4f (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .clk_in  (clk_4f),
    .err_clr (err_clr),
    .locked  (locked_4f),
    .err     (err_4f)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= locked_f & locked_2f & locked_4f;
    end
  end

  assign all_locked = r_all_locked;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: random divided-clock waveforms scored against a period/timestamp model.
module tb_clk_div_monitor;

  localparam int LOCK_CNT = 4;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  logic clk_f   = 1'b0;
  logic clk_2f  = 1'b0;
  logic clk_4f  = 1'b0;
  logic err_clr = 1'b0;
  logic locked_f, locked_2f, locked_4f, all_locked, err_f, err_2f, err_4f;

  int total = 0;
  int bad   = 0;

  clk_div_monitor dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .clk_f      (clk_f),
    .clk_2f     (clk_2f),
    .clk_4f     (clk_4f),
    .err_clr    (err_clr),
    .locked_f   (locked_f),
    .locked_2f  (locked_2f),
    .locked_4f  (locked_4f),
    .all_locked (all_locked),
    .err_f      (err_f),
    .err_2f     (err_2f),
    .err_4f     (err_4f)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic int nom(input int c);
    return (c == 0) ? 32 : ((c == 1) ? 16 : 8);
  endfunction

  function automatic logic [6:0] outv();
    return {locked_f, locked_2f, locked_4f, all_locked, err_f, err_2f, err_4f};
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_32f);
  endtask

  // Waveform generator: per-channel phase counter, optional one-shot period, optional stuck-low.
  int   ph[3], cur_per[3], hi[3], ovr_per[3];
  bit   hold[3];
  logic lvl[3];

  initial begin
    for (int c = 0; c < 3; c++) begin
      cur_per[c] = nom(c);
      hi[c]      = nom(c) / 2;
      ph[c]      = $urandom_range(0, nom(c) - 1);
      ovr_per[c] = 0;
      hold[c]    = 1'b0;
      lvl[c]     = 1'b0;
    end
    forever begin
      @(negedge clk_32f);
      for (int c = 0; c < 3; c++) begin
        if (hold[c]) begin
          lvl[c] = 1'b0;
          ph[c]  = 0;
        end else begin
          if (ph[c] == 0) begin
            cur_per[c] = (ovr_per[c] != 0) ? ovr_per[c] : nom(c);
            ovr_per[c] = 0;
          end
          lvl[c] = (ph[c] < hi[c]);
          ph[c]  = (ph[c] + 1) % cur_per[c];
        end
      end
      clk_f  = lvl[0];
      clk_2f = lvl[1];
      clk_4f = lvl[2];
    end
  end

  // Reference model: works on the sample index of each rising edge (period = index difference).
  // State codes: 0 idle, 1 acquiring, 2 locked.
  int         m_k;
  int         m_st[3], m_good[3], m_last[3];
  bit         m_prev[3], m_pend[3], m_errv[3];
  bit         m_v, m_rise;
  bit [2:0]   lk_hist[$];
  bit [2:0]   lk2, lk3, lk_now;
  logic [6:0] exp_q[$];

  always @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      m_k = 0;
      exp_q.delete();
      lk_hist.delete();
      lk_hist.push_back(3'b000);
      for (int c = 0; c < 3; c++) begin
        m_st[c] = 0; m_good[c] = 0; m_last[c] = 0;
        m_prev[c] = 1'b0; m_pend[c] = 1'b0; m_errv[c] = 1'b0;
      end
    end else begin
      m_k++;
      for (int c = 0; c < 3; c++)
        m_errv[c] = m_pend[c] ? 1'b1 : (err_clr ? 1'b0 : m_errv[c]);
      lk2 = (m_k >= 2) ? lk_hist[m_k - 2] : 3'b000;
      lk3 = (m_k >= 3) ? lk_hist[m_k - 3] : 3'b000;
      exp_q.push_back({lk2[0], lk2[1], lk2[2], &lk3, m_errv[0], m_errv[1], m_errv[2]});
      for (int c = 0; c < 3; c++) begin
        m_v       = (c == 0) ? clk_f : ((c == 1) ? clk_2f : clk_4f);
        m_rise    = m_v & ~m_prev[c];
        m_pend[c] = 1'b0;
        if (m_rise) begin
          if (m_st[c] == 0) begin
            m_st[c] = 1; m_good[c] = 0;
          end else if (m_k - m_last[c] == nom(c)) begin
            if (m_st[c] == 1) begin
              m_good[c]++;
              if (m_good[c] == LOCK_CNT) m_st[c] = 2;
            end
          end else begin
            if (m_st[c] == 2) m_pend[c] = 1'b1;
            m_st[c] = 1; m_good[c] = 0;
          end
          m_last[c] = m_k;
        end else if (m_st[c] != 0 && m_k - m_last[c] == 2 * nom(c)) begin
          if (m_st[c] == 2) m_pend[c] = 1'b1;
          m_st[c] = 0;
        end
`ifdef DUTY_CHECK_EN
        else if (!m_v && m_prev[c] && m_st[c] != 0 && (m_k - m_last[c]) != nom(c) / 2) begin
          if (m_st[c] == 2) m_pend[c] = 1'b1;
          m_st[c] = 1; m_good[c] = 0;
        end
`endif
        m_prev[c] = m_v;
      end
      lk_now = {m_st[2] == 2, m_st[1] == 2, m_st[0] == 2};
      lk_hist.push_back(lk_now);
    end
  end

  // Monitor: every cycle after reset the DUT presents a new output word.
  logic [6:0] sb_e;
  int         cyc_cnt = 0;

  always @(negedge clk_32f) begin
    cyc_cnt++;
    if (reset_L && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      total++;
      if (outv() !== sb_e) begin
        bad++;
        $display("FAIL sb_outputs cyc=%0d got=%b expected=%b", cyc_cnt, outv(), sb_e);
      end
    end
  end

  bit found;
  int rc, ra, rd;

  initial begin
    // Scenario 1: reset, then acquisition from the nominal generator.
    cyc(4);
    chk("reset_state", {1'b0, outv()}, 8'h00);
    reset_L = 1'b1;
    cyc((LOCK_CNT + 1) * 8 + 8);
    chk("lock_4f_bound", {7'd0, locked_4f}, 8'h01);
    cyc((LOCK_CNT + 1) * 16 - (LOCK_CNT + 1) * 8);
    chk("lock_2f_bound", {7'd0, locked_2f}, 8'h01);
    cyc((LOCK_CNT + 1) * 32 - (LOCK_CNT + 1) * 16);
    chk("lock_f_bound", {7'd0, locked_f}, 8'h01);
    chk("no_err_at_lock", {5'd0, err_f, err_2f, err_4f}, 8'h00);
    cyc(2);
    chk("all_locked_follows", {7'd0, all_locked}, 8'h01);

    // Scenario 2: clk_2f stuck low.
    hold[1] = 1'b1;
    cyc(40);
    chk("stuck_2f_state", {6'd0, locked_2f, err_2f}, 8'h01);
    chk("stuck_others", {4'd0, locked_f, locked_4f, err_f, err_4f}, 8'h0c);
    hold[1] = 1'b0;
    cyc(100);
    chk("relock_2f", {7'd0, locked_2f}, 8'h01);

    // Scenario 3: a single 7-cycle clk_4f period.
    ovr_per[2] = 7;
    cyc(20);
    chk("short_4f_drop", {6'd0, locked_4f, err_4f}, 8'h01);
    cyc(60);
    chk("short_4f_relock", {6'd0, locked_4f, err_4f}, 8'h03);

    // Scenario 4: clear alone, then clear colliding with a new error.
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_alone_all", {5'd0, err_f, err_2f, err_4f}, 8'h00);
    hold[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_32f);
      #1;
      if (m_pend[0]) found = 1'b1;
    end
    chk("err_f_window_found", {7'd0, found}, 8'h01);
    @(negedge clk_32f);
    err_clr = 1'b1;
    @(negedge clk_32f);
    err_clr = 1'b0;
    chk("set_beats_clr", {7'd0, err_f}, 8'h01);
    cyc(3);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_alone_f", {7'd0, err_f}, 8'h00);
    hold[0] = 1'b0;

    // Scenario 5: asynchronous reset between clock edges while locked.
    cyc(200);
    chk("pre_reset_locked", {7'd0, all_locked}, 8'h01);
    #3;
    reset_L = 1'b0;
    #1;
    chk("async_reset_now", {1'b0, outv()}, 8'h00);
    cyc(3);
    reset_L = 1'b1;
    cyc((LOCK_CNT + 1) * 32 + 8);
    chk("relock_after_reset", {5'd0, locked_f, locked_2f, locked_4f}, 8'h07);
    cyc(2);
    chk("all_after_reset", {7'd0, all_locked}, 8'h01);

    // Scenario 6: clk_4f high time 5 of 8.
    hi[2] = 5;
    cyc(100);
`ifdef DUTY_CHECK_EN
    chk("duty_4f_err", {7'd0, err_4f}, 8'h01);
`else
    chk("duty_4f_ignored", {6'd0, locked_4f, err_4f}, 8'h02);
`endif

    // Random perturbations, scored cycle by cycle against the model.
    for (int r = 0; r < 40; r++) begin
      rc = $urandom_range(0, 2);
      ra = $urandom_range(0, 3);
      case (ra)
        0: begin
          rd = $urandom_range(1, 2);
          if ($urandom_range(0, 1) == 0) rd = -rd;
          ovr_per[rc] = nom(rc) + rd;
        end
        1: begin
          hold[rc] = 1'b1;
          cyc($urandom_range(5, 70));
          hold[rc] = 1'b0;
        end
        2: hi[rc] = $urandom_range(1, nom(rc) - 1);
        default: begin
          err_clr = 1'b1;
          cyc(1);
          err_clr = 1'b0;
        end
      endcase
      cyc($urandom_range(10, 80));
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
